// File: rtl/mcyc_pkg.sv
// Shared types and constants for the M-/T-cycle trace checker.
package mcyc_pkg;

  // Upper bound on the number of M-cycles a single run may trace.
  localparam int unsigned MAX_MCYC = 16;

  // One bus access as seen during a single M-cycle.
  typedef struct packed {
    logic [15:0] adr;
    logic        wr;
    logic [7:0]  dat;
  } bus_ent_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } trace_state_t;

endpackage

// File: rtl/mcyc_counter.sv
// T-state / M-cycle counter: loads M1T1 on start, advances while running and
// holds at the terminal M-cycle/T-state.
module mcyc_counter #(
  parameter int unsigned NumMcyc = 6,
  parameter int unsigned Tpm     = 4,
  parameter int unsigned Iw      = $clog2(NumMcyc + 1)
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  input  logic          load_i,
  input  logic          adv_i,
  output logic [Iw-1:0] mcyc_o,
  output logic [3:0]    tcyc_o,
  output logic          last_o
);

  localparam logic [Iw-1:0] LastM = Iw'(NumMcyc);
  localparam logic [3:0]    LastT = 4'(Tpm);

  logic [Iw-1:0] mcyc_q, mcyc_d;
  logic [3:0]    tcyc_q, tcyc_d;

  assign last_o = (mcyc_q == LastM) && (tcyc_q == LastT);
  assign mcyc_o = mcyc_q;
  assign tcyc_o = tcyc_q;

  // Next count: load wins, otherwise step T and wrap into the next M-cycle.
  always_comb begin
    mcyc_d = mcyc_q;
    tcyc_d = tcyc_q;
    if (load_i) begin
      mcyc_d = Iw'(1);
      tcyc_d = 4'd1;
    end else if (adv_i && !last_o) begin
      if (tcyc_q == LastT) begin
        tcyc_d = 4'd1;
        mcyc_d = mcyc_q + Iw'(1);
      end else begin
        tcyc_d = tcyc_q + 4'd1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      mcyc_q <= '0;
      tcyc_q <= '0;
    end else begin
      mcyc_q <= mcyc_d;
      tcyc_q <= tcyc_d;
    end
  end

endmodule

// File: rtl/mcyc_trace_checker.sv
// Passive bus tracker: captures one access per M-cycle, checks it against a
// programmable expected table and latches the first mismatching M-cycle.
module mcyc_trace_checker
  import mcyc_pkg::*;
#(
  parameter int unsigned NumMcyc = 6,
  parameter int unsigned Tpm     = 4,
  parameter int unsigned AdrT    = 2,
  parameter int unsigned DatT    = 3,
  parameter int unsigned Iw      = $clog2(NumMcyc + 1)
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  input  logic          start_i,
  input  logic [15:0]   adr_i,
  input  logic          wr_i,
  input  logic          rd_i,
  input  logic [7:0]    dout_i,
  input  logic          exp_we_i,
  input  logic [Iw-1:0] exp_idx_i,
  input  logic          exp_chk_i,
  input  logic [15:0]   exp_adr_i,
  input  logic          exp_wr_i,
  input  logic [7:0]    exp_dat_i,
  output logic [Iw-1:0] mcyc_o,
  output logic [2:0]    tcyc_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [Iw-1:0] err_mcyc_o,
  input  logic [Iw-1:0] cap_idx_i,
  output logic [15:0]   cap_adr_o,
  output logic          cap_wr_o,
  output logic [7:0]    cap_dat_o,
  output logic          cap_vld_o
);

  localparam logic [Iw-1:0] LastM    = Iw'(NumMcyc);
  localparam logic [3:0]    AdrTV    = 4'(AdrT);
  localparam logic [3:0]    DatTV    = 4'(DatT);
  // When the address phase precedes the data phase the check uses the stored
  // capture; otherwise the bus is still live at the check edge.
  localparam bit            AdrFirst = (AdrT < DatT);

  trace_state_t  state_q;
  logic          busy_q, done_q, err_q;
  logic [Iw-1:0] err_mcyc_q;

  // Entry 0 is never written; index 0 is treated as out of range.
  logic [NumMcyc:0] exp_chk_q;
  bus_ent_t         exp_ent_q [NumMcyc+1];
  logic [NumMcyc:0] cap_vld_q;
  logic [NumMcyc:0] cap_ill_q;
  bus_ent_t         cap_ent_q [NumMcyc+1];

  logic [Iw-1:0] mcyc, cur_i, exp_i, cap_i;
  logic [3:0]    tcyc;
  logic          last, running, load;
  logic          cur_ok, exp_ok, cap_ok, adr_edge, dat_edge;
  logic          live_wr, live_ill, eff_wr, eff_ill, mism;
  logic [15:0]   eff_adr;
  bus_ent_t      cur_exp, cur_cap;

  assign running  = (state_q == StRun);
  assign load     = start_i && !running;

  mcyc_counter #(
    .NumMcyc (NumMcyc),
    .Tpm     (Tpm),
    .Iw      (Iw)
  ) u_counter (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .load_i   (load),
    .adv_i    (running),
    .mcyc_o   (mcyc),
    .tcyc_o   (tcyc),
    .last_o   (last)
  );

  assign cur_ok   = (mcyc != '0) && (mcyc <= LastM);
  assign exp_ok   = (exp_idx_i != '0) && (exp_idx_i <= LastM);
  assign cap_ok   = (cap_idx_i != '0) && (cap_idx_i <= LastM);
  assign cur_i    = cur_ok ? mcyc : '0;
  assign exp_i    = exp_ok ? exp_idx_i : '0;
  assign cap_i    = cap_ok ? cap_idx_i : '0;

  assign adr_edge = running && cur_ok && (tcyc == AdrTV);
  assign dat_edge = running && cur_ok && (tcyc == DatTV);

  // rd and wr together is an illegal bus state: recorded as a read.
  assign live_wr  = wr_i & ~rd_i;
  assign live_ill = wr_i & rd_i;
  assign cur_exp  = exp_ent_q[cur_i];
  assign cur_cap  = cap_ent_q[cur_i];

  // Values the check sees at the data edge, and the mismatch decision.
  always_comb begin
    eff_adr = AdrFirst ? cur_cap.adr : adr_i;
    eff_wr  = AdrFirst ? cur_cap.wr : live_wr;
    eff_ill = AdrFirst ? cap_ill_q[cur_i] : live_ill;
    mism    = exp_chk_q[cur_i] &&
              (eff_ill || (eff_adr != cur_exp.adr) || (eff_wr != cur_exp.wr) ||
               (cur_exp.wr && (dout_i != cur_exp.dat)));
  end

  // Expected table: written in any state, cleared only by reset.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      exp_chk_q <= '0;
      for (int unsigned i = 0; i <= NumMcyc; i++) exp_ent_q[i] <= '0;
    end else if (exp_we_i && exp_ok) begin
      exp_chk_q[exp_i] <= exp_chk_i;
      exp_ent_q[exp_i] <= '{adr: exp_adr_i, wr: exp_wr_i, dat: exp_dat_i};
    end
  end

  // Capture table: address/direction at the address edge, data at the data edge.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cap_vld_q <= '0;
      cap_ill_q <= '0;
      for (int unsigned i = 0; i <= NumMcyc; i++) cap_ent_q[i] <= '0;
    end else if (load) begin
      cap_vld_q <= '0;
    end else begin
      if (adr_edge) begin
        cap_ent_q[cur_i].adr <= adr_i;
        cap_ent_q[cur_i].wr  <= live_wr;
        cap_vld_q[cur_i]     <= 1'b1;
        cap_ill_q[cur_i]     <= live_ill;
      end
      if (dat_edge && eff_wr) begin
        cap_ent_q[cur_i].dat <= dout_i;
      end
    end
  end

  // Run control FSM with registered status outputs.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_mcyc_q <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q    <= StRun;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_mcyc_q <= '0;
          end
        end
        StRun: begin
          if (dat_edge && mism && !err_q) begin
            err_q      <= 1'b1;
            err_mcyc_q <= mcyc;
          end
          if (last) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mcyc_o     = mcyc;
  assign tcyc_o     = tcyc[2:0];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_mcyc_o = err_mcyc_q;
  assign cap_adr_o  = cap_ok ? cap_ent_q[cap_i].adr : '0;
  assign cap_wr_o   = cap_ok ? cap_ent_q[cap_i].wr : 1'b0;
  assign cap_dat_o  = cap_ok ? cap_ent_q[cap_i].dat : '0;
  assign cap_vld_o  = cap_ok & cap_vld_q[cap_i];

endmodule
